// File: rtl/result_collector.sv
// Return-path collector for the 4-core array: buffers per-core results and
// retires them to one valid/ready output in dispatch order.
module result_collector #(
    parameter int ORD_DEPTH = 16,
    parameter int RES_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_valid,
    input  logic [1:0]                     disp_core,
    input  logic [3:0]                     res_valid,
    input  logic [31:0]                    res_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_data,
    output logic [1:0]                     out_core,
    output logic [$clog2(ORD_DEPTH+1)-1:0] pending,
    output logic                           ord_ovf,
    output logic [3:0]                     res_ovf
);

    localparam int NUM_CORES = 4;
    localparam int OAW = $clog2(ORD_DEPTH);
    localparam int OCW = $clog2(ORD_DEPTH + 1);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam logic [OCW-1:0] ORD_FULL = OCW'(ORD_DEPTH);
    localparam logic [RCW-1:0] RES_FULL = RCW'(RES_DEPTH);

    // ------------------------------------------------------------------
    // Order queue: core IDs in dispatch order; pending is its count.
    // ------------------------------------------------------------------
    logic [1:0]     ord_mem [ORD_DEPTH];
    logic [OAW-1:0] ord_wr_ptr;
    logic [OAW-1:0] ord_rd_ptr;
    logic           ord_full;
    logic           ord_empty;
    logic           ord_push;
    logic           ord_pop;
    logic [1:0]     head_core;

    logic [NUM_CORES-1:0] res_nonempty;
    logic [7:0]           res_head [NUM_CORES];
    logic                 slot_free;
    logic                 fire;

    assign ord_full  = (pending == ORD_FULL);
    assign ord_empty = (pending == '0);
    assign ord_push  = disp_valid && !ord_full;
    assign head_core = ord_mem[ord_rd_ptr];

    // Retire decision uses only registered state; a result pushed this
    // edge becomes eligible on the next one.
    assign slot_free = !out_valid || out_ready;
    assign fire      = slot_free && !ord_empty && res_nonempty[head_core];
    assign ord_pop   = fire;

    // NOTE: storage arrays carry no reset; validity is tracked entirely by
    // the pointers and counts, so clearing those discards all contents.
    always_ff @(posedge clk) begin
        if (ord_push) begin
            ord_mem[ord_wr_ptr] <= disp_core;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers sample pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ord_wr_ptr <= '0;
            ord_rd_ptr <= '0;
            pending    <= '0;
            ord_ovf    <= 1'b0;
        end else begin
            if (ord_push) begin
                ord_wr_ptr <= ord_wr_ptr + OAW'(1);
            end
            if (ord_pop) begin
                ord_rd_ptr <= ord_rd_ptr + OAW'(1);
            end
            case ({ord_push, ord_pop})
                2'b10:   pending <= pending + OCW'(1);
                2'b01:   pending <= pending - OCW'(1);
                default: pending <= pending;
            endcase
            if (disp_valid && ord_full) begin
                ord_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-core result FIFOs; all four may push in the same cycle.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_res
        logic [7:0]     mem [RES_DEPTH];
        logic [RAW-1:0] wr_ptr;
        logic [RAW-1:0] rd_ptr;
        logic [RCW-1:0] cnt;
        logic           full;
        logic           push;
        logic           pop;
        logic           ovf;

        assign full = (cnt == RES_FULL);
        assign push = res_valid[g] && !full;
        assign pop  = fire && (head_core == 2'(g));

        assign res_nonempty[g] = (cnt != '0);
        assign res_head[g]     = mem[rd_ptr];
        assign res_ovf[g]      = ovf;

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= res_data[8*g +: 8];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + RAW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + RAW'(1);
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + RCW'(1);
                    2'b01:   cnt <= cnt - RCW'(1);
                    default: cnt <= cnt;
                endcase
                // Full is judged pre-edge, so a same-cycle pop does not
                // rescue a push into a full FIFO.
                if (res_valid[g] && full) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads on fire, drains when the slot is free.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_core  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= res_head[head_core];
            out_core  <= head_core;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: a vector table for the ordering and
// backpressure cases plus hand sequences for overflow and mid-run reset.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic [1:0]  disp_core;
    logic [3:0]  res_valid;
    logic [31:0] res_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_core;
    logic [4:0]  pending;
    logic        ord_ovf;
    logic [3:0]  res_ovf;

    int total = 0;
    int bad   = 0;

    result_collector #(.ORD_DEPTH(16), .RES_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_valid (disp_valid),
        .disp_core  (disp_core),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_core   (out_core),
        .pending    (pending),
        .ord_ovf    (ord_ovf),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [1:0]  dc;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        rdy;
        logic        eov;
        logic [7:0]  edata;
        logic [1:0]  ecore;
        logic [4:0]  epend;
        logic        eord;
        logic [3:0]  eres;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic dv, input logic [1:0] dc,
                                input logic [3:0] rv, input logic [31:0] rd,
                                input logic rdy, input logic eov,
                                input logic [7:0] edata, input logic [1:0] ecore,
                                input logic [4:0] epend, input logic eord,
                                input logic [3:0] eres);
        vec_t v;
        v.dv = dv; v.dc = dc; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.eov = eov; v.edata = edata; v.ecore = ecore;
        v.epend = epend; v.eord = eord; v.eres = eres;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, compare outputs 1ns later.
    task automatic step(input vec_t v, input string tag);
        disp_valid = v.dv;
        disp_core  = v.dc;
        res_valid  = v.rv;
        res_data   = v.rd;
        out_ready  = v.rdy;
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(v.eov));
        if (v.eov) begin
            check({tag, " out_data"}, 32'(out_data), 32'(v.edata));
            check({tag, " out_core"}, 32'(out_core), 32'(v.ecore));
        end
        check({tag, " pending"}, 32'(pending), 32'(v.epend));
        check({tag, " ord_ovf"}, 32'(ord_ovf), 32'(v.eord));
        check({tag, " res_ovf"}, 32'(res_ovf), 32'(v.eres));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_data"},  32'(out_data),  32'd0);
        check({tag, " out_core"},  32'(out_core),  32'd0);
        check({tag, " pending"},   32'(pending),   32'd0);
        check({tag, " ord_ovf"},   32'(ord_ovf),   32'd0);
        check({tag, " res_ovf"},   32'(res_ovf),   32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        disp_valid = 1'b0;
        disp_core  = '0;
        res_valid  = '0;
        res_data   = '0;
        out_ready  = 1'b1;

        // Reverse-order returns retire in dispatch order.
        tbl.push_back(mk(1, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(1, 2, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 3, 0, 0));
        tbl.push_back(mk(1, 3, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1000, 32'h4400_0000,  1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0100, 32'h0033_0000,  1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0010, 32'h0000_2200,  1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 32'h0000_0011,  1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h11, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h22, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h33, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h44, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 0, 0, 0));
        // Head-of-line blocking: core0 result waits for the slow core2.
        tbl.push_back(mk(1, 2, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0001, 32'h0000_005A,  1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0100, 32'h00A5_0000,  1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'hA5, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h5A, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 0, 0, 0));
        // Backpressure: 0x01 held while out_ready is low, then a burst.
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0100,  0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0200,  0, 1, 8'h01, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4'b0010, 32'h0000_0300,  0, 1, 8'h01, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          0, 1, 8'h01, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          0, 1, 8'h01, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          0, 1, 8'h01, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h02, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'h03, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 0, 0, 0));
        // All four cores push at once; retire follows dispatch order 3,1,0,2.
        tbl.push_back(mk(1, 3, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 3, 0, 0));
        tbl.push_back(mk(1, 2, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 32'hA3A2_A1A0,  1, 0, 8'h00, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'hA3, 3, 3, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'hA1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'hA0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 1, 8'hA2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 32'h0,          1, 0, 8'h00, 0, 0, 0, 0));

        #12;
        check_cleared("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Result FIFO overflow on core3: fifth push dropped, first four kept.
        for (int k = 0; k < 5; k++) begin
            step(mk(0, 0, 4'b1000, {8'(8'hC0 + k), 24'h0}, 1, 0, 8'h00, 0, 0, 0,
                    (k == 4) ? 4'b1000 : 4'b0000), $sformatf("res_ovf%0d", k));
        end
        step(mk(1, 3, 4'b0000, 32'h0, 1, 0, 8'h00, 0, 1, 0, 4'b1000), "drain0");
        step(mk(1, 3, 4'b0000, 32'h0, 1, 1, 8'hC0, 3, 1, 0, 4'b1000), "drain1");
        step(mk(1, 3, 4'b0000, 32'h0, 1, 1, 8'hC1, 3, 1, 0, 4'b1000), "drain2");
        step(mk(1, 3, 4'b0000, 32'h0, 1, 1, 8'hC2, 3, 1, 0, 4'b1000), "drain3");
        step(mk(0, 0, 4'b0000, 32'h0, 1, 1, 8'hC3, 3, 0, 0, 4'b1000), "drain4");
        step(mk(1, 3, 4'b0000, 32'h0, 1, 0, 8'h00, 0, 1, 0, 4'b1000), "dropped0");
        step(mk(0, 0, 4'b0000, 32'h0, 1, 0, 8'h00, 0, 1, 0, 4'b1000), "dropped1");

        // Order queue overflow: head core3 has no data, so nothing retires.
        for (int j = 1; j <= 17; j++) begin
            step(mk(1, 0, 4'b0000, 32'h0, 1, 0, 8'h00, 0,
                    5'((j + 1 > 16) ? 16 : j + 1), (j >= 16), 4'b1000),
                 $sformatf("ord_ovf%0d", j));
        end

        rst = 1'b1;
        #1;
        check_cleared("rst_flags");
        #1;
        rst = 1'b0;

        // Build pending=6 with a stalled valid output, then reset mid-run.
        step(mk(1, 1, 4'b0010, 32'h0000_7700, 0, 0, 8'h00, 0, 1, 0, 0), "build0");
        for (int k = 0; k < 6; k++) begin
            step(mk(1, 0, 4'b0000, 32'h0, 0, 1, 8'h77, 1, 5'(k + 1), 0, 0),
                 $sformatf("build%0d", k + 1));
        end
        rst = 1'b1;
        #1;
        check_cleared("rst_mid");
        #1;
        rst = 1'b0;

        step(mk(1, 2, 4'b0000, 32'h0,         1, 0, 8'h00, 0, 1, 0, 0), "post0");
        step(mk(0, 0, 4'b0100, 32'h003C_0000, 1, 0, 8'h00, 0, 1, 0, 0), "post1");
        step(mk(0, 0, 4'b0000, 32'h0,         1, 1, 8'h3C, 2, 0, 0, 0), "post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
